// File: rtl/usr_pkg.sv
// Shared types for the parametrised universal shift register.
// Holds the 3-bit operation codes and the command FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Modes that finish on the launch edge of a multi-step command.
    function automatic logic mode_is_instant(input logic [2:0] m);
        return (m == MODE_HOLD) || (m == MODE_LOAD) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-step next-value function of the shift register.
// Ports: q_i current value, mode_i op code, sin_l_i/sin_r_i serial in,
//        pin_i parallel data, q_o value after one step.
module usr_step_logic
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] q_o
);

    mode_e mode;

    always_comb begin
        mode = mode_e'(mode_i);
        q_o  = q_i;
        unique case (mode)
            MODE_SHR:  q_o = {sin_l_i, q_i[WIDTH-1:1]};
            MODE_SHL:  q_o = {q_i[WIDTH-2:0], sin_r_i};
            MODE_LOAD: q_o = pin_i;
            MODE_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_HOLD: q_o = q_i;
            MODE_RSVD: q_o = q_i;
            default:   q_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_param.sv
// Parametrised universal shift register with a multi-step command engine.
// Ports: clk, rst_n (async low), en, mode, start, amt, sin_l, sin_r, pin in;
//        q, sout_r, sout_l, busy, done out.
module univ_shift_reg_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic                   start,
    input  logic [$clog2(WIDTH):0] amt,
    input  logic                   sin_l,
    input  logic                   sin_r,
    input  logic [WIDTH-1:0]       pin,
    output logic [WIDTH-1:0]       q,
    output logic                   sout_r,
    output logic                   sout_l,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mlat_q, mlat_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;

    // RUN replays the latched command; IDLE follows the live mode input.
    assign step_mode = (state_q == RUN) ? mlat_q : mode;

    usr_step_logic #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i     (reg_q),
        .mode_i  (step_mode),
        .sin_l_i (sin_l),
        .sin_r_i (sin_r),
        .pin_i   (pin),
        .q_o     (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mlat_d  = mlat_q;
        reg_d   = reg_q;
        busy_d  = busy_q;
        // done is a single-cycle pulse, cleared even while stalled
        done_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mlat_d = mode;
                        if ((amt == '0) || mode_is_instant(mode)) begin
                            if (mode == MODE_LOAD) begin
                                reg_d = step_q;
                            end
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            cnt_d   = amt;
                            state_d = RUN;
                        end
                    end else begin
                        reg_d = step_q;
                    end
                end
                RUN: begin
                    reg_d = step_q;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mlat_q  <= '0;
            reg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mlat_q  <= mlat_d;
            reg_q   <= reg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q      = reg_q;
    assign sout_r = reg_q[0];
    assign sout_l = reg_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed self-checking bench for univ_shift_reg_param (WIDTH=8).
// Expected values are hand-computed constants.
module tb_univ_shift_reg_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic       start;
    logic [3:0] amt;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] pin;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg_param #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .start  (start),
        .amt    (amt),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .pin    (pin),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [7:0] eq,
                      input logic eb, input logic ed);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, ed});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode  = 3'b011;
        pin   = v;
        start = 1'b0;
        tick();
        mode  = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 3'b000; start = 1'b0;
        amt = 4'd0; sin_l = 1'b0; sin_r = 1'b0; pin = 8'h00;
        tick(); tick();
        st("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.sout_r", {7'd0, sout_r}, 8'h00);
        rst_n = 1'b1;
        en    = 1'b1;

        // single-step load
        load(8'hA5);
        st("load", 8'hA5, 1'b0, 1'b0);
        chk("load.sout_r", {7'd0, sout_r}, 8'h01);
        chk("load.sout_l", {7'd0, sout_l}, 8'h01);

        // single-step SHR with sin_l=1
        mode = 3'b001; sin_l = 1'b1;
        tick(); chk("shr1", q, 8'hD2);
        tick(); chk("shr2", q, 8'hE9);
        tick(); chk("shr3", q, 8'hF4);
        sin_l = 1'b0;

        // single-step SHL, ROR
        mode = 3'b010; sin_r = 1'b1;
        tick(); chk("shl", q, 8'hE9);
        mode = 3'b100;
        tick(); chk("ror", q, 8'hF4);
        sin_r = 1'b0;

        // ROL x4 command
        load(8'hA5);
        mode = 3'b101; amt = 4'd4; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b011; pin = 8'h00;
        st("rol.go", 8'hA5, 1'b1, 1'b0);
        tick(); st("rol.1", 8'h4B, 1'b1, 1'b0);
        tick(); st("rol.2", 8'h96, 1'b1, 1'b0);
        tick(); st("rol.3", 8'h2D, 1'b1, 1'b0);
        tick(); st("rol.4", 8'h5A, 1'b0, 1'b1);
        mode = 3'b000;
        tick(); st("rol.after", 8'h5A, 1'b0, 1'b0);

        // ASR x2 command
        load(8'h85);
        mode = 3'b110; amt = 4'd2; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        st("asr.go", 8'h85, 1'b1, 1'b0);
        tick(); st("asr.1", 8'hC2, 1'b1, 1'b0);
        tick(); st("asr.2", 8'hE1, 1'b0, 1'b1);
        tick(); st("asr.after", 8'hE1, 1'b0, 1'b0);

        // ASR x2 with a 3-cycle stall; done clears while en=0
        load(8'h85);
        mode = 3'b110; amt = 4'd2; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        tick(); st("stall.1", 8'hC2, 1'b1, 1'b0);
        en = 1'b0;
        tick(); st("stall.a", 8'hC2, 1'b1, 1'b0);
        tick(); st("stall.b", 8'hC2, 1'b1, 1'b0);
        tick(); st("stall.c", 8'hC2, 1'b1, 1'b0);
        en = 1'b1;
        tick(); st("stall.2", 8'hE1, 1'b0, 1'b1);
        en = 1'b0;
        tick(); st("stall.done_clr", 8'hE1, 1'b0, 1'b0);
        en = 1'b1;

        // amt=0 finishes immediately
        load(8'h3C);
        mode = 3'b001; amt = 4'd0; start = 1'b1; sin_l = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        st("amt0", 8'h3C, 1'b0, 1'b1);
        tick(); st("amt0.after", 8'h3C, 1'b0, 1'b0);
        sin_l = 1'b0;

        // start during RUN is ignored
        mode = 3'b010; amt = 4'd2; start = 1'b1; sin_r = 1'b0;
        tick();
        mode = 3'b011; pin = 8'h00; amt = 4'd7;
        st("ign.go", 8'h3C, 1'b1, 1'b0);
        tick(); st("ign.1", 8'h78, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); st("ign.2", 8'hF0, 1'b0, 1'b1);

        // LOAD command: loads and completes on the launch edge
        mode = 3'b011; pin = 8'h5A; amt = 4'd5; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        st("ldcmd", 8'h5A, 1'b0, 1'b1);

        // SHR x10 overshoots the width and fills with sin_l
        mode = 3'b001; amt = 4'd10; start = 1'b1; sin_l = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        for (int i = 0; i < 9; i++) tick();
        chk("shr10.busy", {7'd0, busy}, 8'h01);
        tick(); st("shr10", 8'hFF, 1'b0, 1'b1);
        sin_l = 1'b0;

        // asynchronous reset mid-command
        mode = 3'b010; amt = 4'd5; start = 1'b1;
        tick(); start = 1'b0; mode = 3'b000;
        st("rst.pre", 8'hFF, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        st("rst.async", 8'h00, 1'b0, 1'b0);
        chk("rst.sout_l", {7'd0, sout_l}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick(); st("rst.post1", 8'h00, 1'b0, 1'b0);
        tick(); st("rst.post2", 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
